// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
//
// Takes a length-prefixed byte stream over a valid/ready handshake. The first two
// bytes are the big-endian word count N. The next 4N bytes are packed into 32-bit
// big-endian words. Each word is written in one single-cycle write to
// BASE_ADDR + 4*k. The CPU is held until the whole image has been written.
//
// Parameters:
//   ADDR_WIDTH  log2 of instruction memory depth in words (max image 2^ADDR_WIDTH words)
//   BASE_ADDR   byte address of the first word; must be 4-aligned
//
// Ports:
//   clock       rising-edge clock, shared with PC and i_mem
//   reset_n     asynchronous active-low reset
//   start       single-cycle pulse that begins a load session (ignored while busy)
//   byte_in     stream byte
//   byte_valid  byte_in is valid
//   byte_ready  loader accepts a byte this cycle
//   mem_we      instruction memory write enable, one cycle per word
//   mem_addr    byte address of the word being written (held between writes)
//   mem_wdata   word being written (held between writes)
//   cpu_hold    high = PC must not advance
//   busy        session in progress
//   done        image fully written; sticky until the next start
//   error       invalid length header; sticky until the next start
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StWrite,
        StDone,
        StErr
    } state_e;

    localparam logic [31:0] MaxWords = 32'd1 << ADDR_WIDTH;

    state_e      state;
    logic [15:0] len;        // word count N
    logic [31:0] k;          // index of the word currently being assembled/written
    logic [1:0]  idx;        // byte position within the current word
    logic [23:0] shift;      // first three bytes of the current word, oldest in [23:16]

    logic        xfer;
    logic [31:0] len_full;   // header value completed by the byte on byte_in
    logic        len_ok;

    assign xfer     = byte_valid && byte_ready;
    assign len_full = {16'd0, len[15:8], byte_in};
    assign len_ok   = (len_full != 32'd0) && (len_full <= MaxWords);

    // All outputs except the write address/data are pure decodes of the state register,
    // so byte_ready never depends combinationally on byte_valid.
    assign byte_ready = (state == StLenHi) || (state == StLenLo) || (state == StData);
    assign busy       = byte_ready || (state == StWrite);
    assign mem_we     = (state == StWrite);
    assign done       = (state == StDone);
    assign error      = (state == StErr);
    // Only a completed image releases the CPU; any start or header error re-holds it.
    assign cpu_hold   = (state != StDone);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= StIdle;
            len       <= 16'd0;
            k         <= 32'd0;
            idx       <= 2'd0;
            shift     <= 24'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            case (state)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        state <= StLenHi;
                        k     <= 32'd0;
                        idx   <= 2'd0;
                    end
                end
                StLenHi: begin
                    if (xfer) begin
                        len[15:8] <= byte_in;
                        state     <= StLenLo;
                    end
                end
                StLenLo: begin
                    if (xfer) begin
                        len[7:0] <= byte_in;
                        idx      <= 2'd0;
                        state    <= len_ok ? StData : StErr;
                    end
                end
                StData: begin
                    if (xfer) begin
                        shift <= {shift[15:0], byte_in};
                        idx   <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            // Address and data are registered here so they are stable
                            // for the whole WRITE cycle.
                            mem_wdata <= {shift, byte_in};
                            mem_addr  <= BASE_ADDR + (k << 2);
                            state     <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    if (k == ({16'd0, len} - 32'd1)) begin
                        state <= StDone;
                    end else begin
                        k     <= k + 32'd1;
                        state <= StData;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader #(
        .ADDR_WIDTH (8),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stream[$];
    int         we_cyc[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         we_count = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write is popped against the scoreboard, independent of stimulus.
    always @(negedge clock) begin
        if (reset_n && mem_we) begin
            we_count++;
            we_cyc.push_back(cyc);
            chk("ready_low_during_write", {63'd0, byte_ready}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {mem_addr, mem_wdata}, 64'd0 - 64'd1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", {32'd0, mem_addr}, {32'd0, e.addr});
                chk("write_data", {32'd0, mem_wdata}, {32'd0, e.data});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send(input logic [7:0] b, input bit rnd);
        bit sent = 0;
        for (int i = 0; i < 200; i++) begin
            if (byte_ready && (!rnd || $urandom_range(0, 2) != 0)) begin
                byte_valid = 1'b1;
                byte_in    = b;
                @(negedge clock);
                byte_valid = 1'b0;
                byte_in    = 8'($urandom);
                sent = 1;
                break;
            end else begin
                // Garbage with valid high is allowed only while the loader is not ready.
                byte_valid = (rnd && !byte_ready) ? 1'($urandom_range(0, 1)) : 1'b0;
                byte_in    = 8'($urandom);
                @(negedge clock);
            end
        end
        if (!sent) chk("send_timeout", 64'd0, 64'd1);
        byte_valid = 1'b0;
    endtask

    task automatic send_stream(input bit rnd);
        foreach (stream[i]) send(stream[i], rnd);
        stream.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Called in the cycle of the final WRITE.
    task automatic chk_done(input string tag);
        chk({tag, "_done_in_write"}, {63'd0, done}, 64'd0);
        @(negedge clock);
        chk({tag, "_done"}, {60'd0, done, busy, cpu_hold, byte_ready}, {60'd0, 4'b1000});
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic load_two_word_image();
        stream = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h00};
        push_wr(32'h0, 32'h2408_0005);
        push_wr(32'h4, 32'hAC09_0000);
    endtask

    initial begin
        int base_we;
        reset_n    = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        @(negedge clock);
        chk("reset_values",
            {byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error},
            {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_hold", {62'd0, cpu_hold, byte_ready}, {62'd0, 2'b10});

        // Full-rate two-word image.
        pulse_start();
        chk("after_start", {60'd0, byte_ready, busy, cpu_hold, done}, {60'd0, 4'b1110});
        load_two_word_image();
        we_cyc.delete();
        send_stream(1'b0);
        chk_done("full_rate");
        chk("five_cycles_per_word", 64'(we_cyc[1] - we_cyc[0]), 64'd5);

        // Same image with byte_valid toggling randomly.
        pulse_start();
        chk("restart_clears_done", {62'd0, done, cpu_hold}, {62'd0, 2'b01});
        load_two_word_image();
        send_stream(1'b1);
        chk_done("random_valid");

        // Header N = 0.
        base_we = we_count;
        pulse_start();
        stream = '{8'h00, 8'h00};
        send_stream(1'b0);
        chk("len0_error", {60'd0, error, cpu_hold, busy, byte_ready}, {60'd0, 4'b1100});
        repeat (4) @(negedge clock);
        chk("len0_no_write", 64'(we_count - base_we), 64'd0);

        // Header N = 2^ADDR_WIDTH + 1.
        pulse_start();
        chk("start_clears_error", {63'd0, error}, 64'd0);
        stream = '{8'h01, 8'h01};
        send_stream(1'b0);
        chk("len257_error", {60'd0, error, cpu_hold, busy, done}, {60'd0, 4'b1100});
        repeat (4) @(negedge clock);
        chk("len257_no_write", 64'(we_count - base_we), 64'd0);

        // Maximum image N = 256.
        pulse_start();
        stream = '{8'h01, 8'h00};
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            stream.push_back(b);
            stream.push_back(8'hA5);
            stream.push_back(~b);
            stream.push_back(8'h3C);
            push_wr(32'(4 * i), {b, 8'hA5, ~b, 8'h3C});
        end
        base_we = we_count;
        send_stream(1'b0);
        chk_done("max_image");
        chk("max_image_writes", 64'(we_count - base_we), 64'd256);

        // Reset during DATA after 3 bytes of word 1.
        pulse_start();
        stream = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h55, 8'h66, 8'h77};
        push_wr(32'h0, 32'h0102_0304);
        send_stream(1'b0);
        reset_n = 1'b0;
        #1;
        chk("midreset_values",
            {byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error},
            {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
        chk("midreset_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        pulse_start();
        stream = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        push_wr(32'h0, 32'hDEAD_BEEF);
        send_stream(1'b0);
        chk_done("after_reset");

        // start while busy is ignored.
        pulse_start();
        load_two_word_image();
        for (int i = 0; i < 4; i++) send(stream[i], 1'b0);
        pulse_start();
        chk("start_while_busy", {62'd0, busy, byte_ready}, {62'd0, 2'b11});
        for (int i = 4; i < 10; i++) send(stream[i], 1'b0);
        stream.delete();
        chk_done("busy_start");

        // start after DONE begins a fresh session.
        pulse_start();
        chk("restart_after_done", {61'd0, done, cpu_hold, busy}, {61'd0, 3'b011});
        stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        push_wr(32'h0, 32'h1122_3344);
        send_stream(1'b0);
        chk_done("restart");

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the core's instruction memory. Accepts a length-prefixed byte stream over a valid/ready handshake and packs it into 32-bit big-endian words. Issues one single-cycle write per word at word-aligned byte addresses compatible with the PC/fetch path. Holds the CPU (PC update) frozen until a complete image has been written.

## Interface
Parameters:
- ADDR_WIDTH, 8, log2 of instruction memory depth in words; max image = 2^ADDR_WIDTH words
- BASE_ADDR, 32'h0000_0000, byte address of first word written; must be 4-aligned

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  rising-edge clock, shared with PC and i_mem
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that begins a load session
- byte_in  in  8  stream byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write enable, one cycle per word
- mem_addr  out  32  byte address of the word being written
- mem_wdata  out  32  word being written
- cpu_hold  out  1  high = PC must not advance
- busy  out  1  session in progress
- done  out  1  image fully written; sticky
- error  out  1  invalid length header; sticky

## Operation
- Byte transfer occurs on a rising edge with byte_valid && byte_ready. byte_in is ignored otherwise.
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4N data bytes. The first byte of each group lands in bits 31:24 and the fourth in bits 7:0.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
  - IDLE/DONE/ERR --start--> LEN_HI. Start also clears done/error and zeroes the word counter k.
  - LEN_HI --transfer--> LEN_LO. The byte is latched as N[15:8].
  - LEN_LO --transfer--> DATA if 1 <= N <= 2^ADDR_WIDTH, else ERR.
  - DATA: accepts bytes, with the byte index cycling 0..3. The 4th transfer goes to WRITE.
  - WRITE (exactly 1 cycle): mem_we=1, mem_addr=BASE_ADDR+4*k, mem_wdata=packed word. Next state is DONE if k==N-1; otherwise k increments and the FSM returns to DATA.
- byte_ready is 1 only in LEN_HI, LEN_LO and DATA. It is 0 in WRITE, IDLE, DONE and ERR.
- busy is 1 in LEN_HI, LEN_LO, DATA and WRITE.
- cpu_hold:
  - 1 from reset until the first entry into DONE.
  - Returns to 1 on any start.
  - Stays 1 in ERR.
- k and the address arithmetic are 32-bit. Wrap is impossible because N is bounded by 2^ADDR_WIDTH.
- start while busy is ignored.
- ERR writes nothing; a header error never produces mem_we.
- Asynchronous reset mid-session:
  - Immediately forces IDLE, mem_we=0, byte_ready=0, busy=0, done=0, error=0, cpu_hold=1.
  - Words already written stay in memory; no rollback.

## Timing
- Reset values: byte_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, busy 0, done 0, error 0.
- All outputs are registered or pure decodes of the state register. There is no combinational path from byte_valid to byte_ready.
- start at edge t: state LEN_HI and byte_ready=1 from t+1.
- 4th data byte accepted at edge t: mem_we=1 during cycle t+1; byte_ready=0 during that cycle.
- Streaming back-to-back at full rate: 5 cycles per word (4 transfers + 1 WRITE).
- Last WRITE in cycle t: done=1, busy=0 and cpu_hold=0 from t+1.
- Invalid LEN_LO accepted at edge t: error=1 from t+1.
- mem_addr and mem_wdata are valid only while mem_we=1. Outside writes they hold their last value.

## Test plan
- Reset then start; stream 00 02 | 24 08 00 05 | AC 09 00 00 -> two writes, each followed by a cycle with byte_ready=0:
  - mem_we at (addr 0x0, data 0x24080005), then (addr 0x4, data 0xAC090000);
  - done=1 and cpu_hold=0 the cycle after the 2nd write.
- Same stream with byte_valid toggling randomly -> identical writes and data; no transfer is counted while byte_ready=0.
- Length header 00 00, and separately N = 2^ADDR_WIDTH + 1 (0x0101 for ADDR_WIDTH=8) -> error=1 one cycle after LEN_LO, no mem_we, cpu_hold stays 1.
- N=256 with ADDR_WIDTH=8 -> 256 writes, last at addr 0x3FC, then done.
- Assert reset_n low during DATA after 3 of 4 bytes of word 1 -> outputs immediately at reset values. After release, start with a new image N=1 -> single write at addr 0x0.
- start pulsed while busy -> ignored, session completes unchanged. start after DONE -> done=0 and cpu_hold=1 next cycle, new session proceeds.
